wddl_eval_capture: RTL
======================

# wddl_eval_capture

Precharge/evaluate sequencer and dual-rail capture stage that sits directly downstream of the WDDL gate array: it drives the shared `prechrg_i` net of the gates, waits for the evaluate phase to settle, captures the complementary rail pairs (e.g. `or_o`/`nor_o`) into a single-rail register, and checks dual-rail encoding validity. Each operation checks for the all-zero spacer during precharge and for exactly-one-hot pairs during evaluate. It also flags violations and counts faulty operations for fault-injection and side-channel experiments.

## Interface
Parameters:
- `WIDTH`, 8, number of dual-rail pairs captured.
- `EVAL_CYCLES`, 1, clock cycles `prechrg_o` is held low before sampling; must be at least 1.
- `CNT_W`, 8, width of the error counter.

Ports:
- `clk_i`  in  1  single clock, rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `start_i`  in  1  request one precharge/evaluate operation.
- `t_i`  in  WIDTH  true rails from gate outputs.
- `f_i`  in  WIDTH  false (complement) rails from gate outputs.
- `clr_cnt_i`  in  1  synchronous clear of `err_cnt_o`.
- `prechrg_o`  out  1  to gates' `prechrg_i`; 1 = precharge (rails forced 0), 0 = evaluate.
- `busy_o`  out  1  operation in progress.
- `valid_o`  out  1  one-cycle pulse: `data_o`/`err_o`/`err_mask_o` updated.
- `data_o`  out  WIDTH  captured true rails.
- `err_o`  out  1  operation had any encoding violation; qualified by `valid_o`.
- `err_mask_o`  out  WIDTH  per-pair violation flags of last operation.
- `err_cnt_o`  out  CNT_W  count of faulty operations, saturating.

## Operation
- FSM states IDLE, PRE, EVAL. `prechrg_o` is a register (no combinational glitches on the gate net): 1 in IDLE and PRE, 0 in EVAL.
- IDLE:
  - `busy_o`=0.
  - `start_i`=1 at an edge → PRE; the pending error mask is cleared to 0.
  - `start_i` in any other state is ignored, with no queuing.
- PRE: lasts exactly one cycle. At its closing edge, each pair with `t_i|f_i`≠0 sets its pending mask bit (spacer violation). The eval counter is loaded with EVAL_CYCLES−1. Next state is EVAL.
- EVAL: the counter decrements each edge. At the edge where the counter is 0 (the sample edge):
  - `data_o` ← `t_i`, updated even on error.
  - Each pair with `t_i^f_i`=0 (00 or 11) sets its mask bit.
  - `err_mask_o` ← pending mask | eval violations.
  - `err_o` ← OR of that mask.
  - `valid_o` ← 1.
  - State → IDLE.
- `valid_o` and `err_o` are high for exactly one cycle, then return to 0. `data_o` and `err_mask_o` hold until the next sample edge.
- `err_cnt_o` increments by 1 on the sample edge when the operation is faulty. It saturates at 2^CNT_W−1.
- `clr_cnt_i` clears `err_cnt_o` to 0 at the next edge. Clear has priority over a simultaneous increment (result 0).
- `busy_o` = (state ≠ IDLE).

## Timing
- Reset values:
  - `prechrg_o`=1, asserted asynchronously so the gates precharge immediately.
  - State IDLE.
  - `busy_o`, `valid_o`, `err_o`=0.
  - `data_o`, `err_mask_o`, `err_cnt_o`=0.
- Reset mid-operation: abort. No `valid_o` and no count update for the aborted operation.
- `start_i` sampled at edge n:
  - PRE cycle n→n+1, with the spacer check at edge n+1.
  - `prechrg_o` low from edge n+1 to edge n+1+EVAL_CYCLES.
  - Sample at edge n+1+EVAL_CYCLES.
  - `valid_o` high in the following cycle, with `prechrg_o` already back at 1.
- The earliest next accepted start is edge n+2+EVAL_CYCLES, which is the cycle in which `valid_o` is high. Throughput is one operation per EVAL_CYCLES+2 cycles.
- Pairs are sampled only at the PRE closing edge and the sample edge. Rail values at other times are don't-care.

## Test plan
- WIDTH=8, EVAL_CYCLES=1: `start_i` at edge 0, rails 00 during PRE, then t=0xA5/f=0x5A → `prechrg_o` 0 only between edges 1 and 2; `valid_o` after edge 2; `data_o`=0xA5, `err_o`=0, `err_mask_o`=0x00.
- Back-to-back: hold `start_i`=1 continuously with EVAL_CYCLES=3 → `valid_o` pulses every 5 cycles; `busy_o` low only in the `valid_o` cycle; `start_i` during busy is ignored.
- Spacer fault: pair 2 has t=1 during PRE, valid eval t=0xFF/f=0x00 → `err_o`=1, `err_mask_o`=0x04, `data_o`=0xFF, `err_cnt_o` 0→1.
- Eval faults: pair 0 = 11 and pair 7 = 00 at sample → `err_mask_o`=0x81, `err_o`=1. With CNT_W=2, four faulty operations → `err_cnt_o` stays 3. `clr_cnt_i` coincident with a faulty sample → 0.
- Assert `rst_i` asynchronously mid-EVAL → `prechrg_o`=1 before the next edge; no `valid_o`; all outputs return to their reset values; the next start operates normally.

Source files
------------

// File: rtl/wddl_eval_capture_if.sv
`default_nettype none
// ============================================================================
// Module   : wddl_eval_capture_if
// Purpose  : Bundles the rail, handshake and status signals between the WDDL
//            gate array / controlling logic (master) and the precharge/evaluate
//            capture stage (slave).
// Signals  : start_i, t_i, f_i, clr_cnt_i       master -> slave
//            prechrg_o, busy_o, valid_o, data_o,
//            err_o, err_mask_o, err_cnt_o        slave -> master
// Revision : 1.0 - initial release
// ============================================================================
interface wddl_eval_capture_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             start_i;
  logic [WIDTH-1:0] t_i;
  logic [WIDTH-1:0] f_i;
  logic             clr_cnt_i;
  logic             prechrg_o;
  logic             busy_o;
  logic             valid_o;
  logic [WIDTH-1:0] data_o;
  logic             err_o;
  logic [WIDTH-1:0] err_mask_o;
  logic [CNT_W-1:0] err_cnt_o;

  modport master (
    output start_i, t_i, f_i, clr_cnt_i,
    input  prechrg_o, busy_o, valid_o, data_o, err_o, err_mask_o, err_cnt_o
  );

  modport slave (
    input  start_i, t_i, f_i, clr_cnt_i,
    output prechrg_o, busy_o, valid_o, data_o, err_o, err_mask_o, err_cnt_o
  );
endinterface
`default_nettype wire

// File: rtl/wddl_eval_capture.sv
`default_nettype none
// ============================================================================
// Module   : wddl_eval_capture
// Purpose  : Precharge/evaluate sequencer and dual-rail capture stage for a
//            WDDL gate array. Drives the shared precharge net, checks for the
//            all-zero spacer at the end of precharge and for one-hot rail
//            pairs at the evaluate sample point, captures the true rails and
//            keeps a saturating count of faulty operations.
// Ports    : clk_i      clock, rising edge
//            rst_i      asynchronous active-high reset
//            bus        wddl_eval_capture_if.slave (start, rails, counter
//                       clear in; precharge, busy, valid, data, error
//                       flag/mask and error count out)
// Revision : 1.0 - initial release
// ============================================================================
module wddl_eval_capture #(
  parameter int WIDTH       = 8,
  parameter int EVAL_CYCLES = 1,
  parameter int CNT_W       = 8
) (
  input  wire                    clk_i,
  input  wire                    rst_i,
  wddl_eval_capture_if.slave     bus
);

  localparam int                  c_eval_w    = (EVAL_CYCLES > 1) ? $clog2(EVAL_CYCLES) : 1;
  localparam logic [c_eval_w-1:0] c_eval_load = c_eval_w'(EVAL_CYCLES - 1);
  localparam logic [CNT_W-1:0]    c_cnt_max   = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_EVAL = 2'd2
  } state_t;

  state_t              r_state;
  logic [c_eval_w-1:0] r_eval_cnt;
  logic [WIDTH-1:0]    r_pend_mask;
  logic                r_prechrg;
  logic                r_valid;
  logic                r_err;
  logic [WIDTH-1:0]    r_data;
  logic [WIDTH-1:0]    r_err_mask;
  logic [CNT_W-1:0]    r_err_cnt;

  logic                w_sample;
  logic [WIDTH-1:0]    w_op_mask;
  logic                w_faulty;

  // A valid evaluated pair is exactly one-hot; 00 and 11 both flag.
  assign w_sample  = (r_state == S_EVAL) && (r_eval_cnt == '0);
  assign w_op_mask = r_pend_mask | ~(bus.t_i ^ bus.f_i);
  assign w_faulty  = w_sample && (|w_op_mask);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_eval_cnt  <= '0;
      r_pend_mask <= '0;
      r_prechrg   <= 1'b1;   // gates precharge as soon as reset asserts
      r_valid     <= 1'b0;
      r_err       <= 1'b0;
      r_data      <= '0;
      r_err_mask  <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (bus.start_i) begin
            r_state     <= S_PRE;
            r_pend_mask <= '0;
          end
        end
        S_PRE: begin
          // Any rail high at the end of precharge is a broken spacer.
          r_pend_mask <= bus.t_i | bus.f_i;
          r_eval_cnt  <= c_eval_load;
          r_prechrg   <= 1'b0;
          r_state     <= S_EVAL;
        end
        S_EVAL: begin
          if (r_eval_cnt == '0) begin
            r_data     <= bus.t_i;
            r_err_mask <= w_op_mask;
            r_err      <= |w_op_mask;
            r_valid    <= 1'b1;
            r_prechrg  <= 1'b1;
            r_state    <= S_IDLE;
          end else begin
            r_eval_cnt <= r_eval_cnt - 1'b1;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_prechrg <= 1'b1;
        end
      endcase

      // Clear wins over a coincident increment.
      if (bus.clr_cnt_i) begin
        r_err_cnt <= '0;
      end else if (w_faulty && (r_err_cnt != c_cnt_max)) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  assign bus.prechrg_o  = r_prechrg;
  assign bus.busy_o     = (r_state != S_IDLE);
  assign bus.valid_o    = r_valid;
  assign bus.data_o     = r_data;
  assign bus.err_o      = r_err;
  assign bus.err_mask_o = r_err_mask;
  assign bus.err_cnt_o  = r_err_cnt;

endmodule
`default_nettype wire
